sram_arbiter2: RTL and testbench
================================

# sram_arbiter2

Two-master, one-slave arbiter that shares a single synchronous SRAM-style port (addra/dina/douta/ena/wea, one-cycle read latency) between two requesters. Typical placements: in front of the data SRAM, sharing it between the pipeline data port and a second master (DMA or debug loader); or in front of a unified instruction/data memory. Round-robin arbitration on conflict, grant in the request cycle, and a registered response tag so each read result returns only to its issuer.

## Interface
- LEN_ADDR, 64, address width of masters and slave
- LEN_DATA, 64, data width; byte-enable width is LEN_DATA/8
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset: synchronous, active-high
- m0_req  in  1  master 0 access request
- m0_addra  in  LEN_ADDR  master 0 address
- m0_dina  in  LEN_DATA  master 0 write data
- m0_wea  in  LEN_DATA/8  master 0 byte write enables (all zero = read)
- m0_gnt  out  1  master 0 request accepted this cycle
- m0_douta  out  LEN_DATA  read data (valid only when m0_rvalid)
- m0_rvalid  out  1  master 0 response (read data or write ack) this cycle
- m1_req, m1_addra, m1_dina, m1_wea, m1_gnt, m1_douta, m1_rvalid: same as master 0
- s_addra  out  LEN_ADDR  slave address
- s_dina  out  LEN_DATA  slave write data
- s_wea  out  LEN_DATA/8  slave byte write enables
- s_ena  out  1  slave enable
- s_douta  in  LEN_DATA  slave read data, valid the cycle after s_ena

## Operation
- State: last_gnt (1 bit, master granted most recently), rsp_valid (1 bit), rsp_owner (1 bit).
- Grant (combinational): only m0_req -> m0; only m1_req -> m1; both -> master != last_gnt; neither -> none. At most one gnt high per cycle.
- Slave mux: s_ena = m0_gnt | m1_gnt; s_addra/s_dina/s_wea from the granted master; when no grant, s_wea = 0 and s_addra/s_dina = master 0 values (don't-care, but must be deterministic).
- On a grant: last_gnt <= granted index; rsp_valid <= 1; rsp_owner <= granted index. No grant: rsp_valid <= 0, last_gnt held.
- Response: mX_rvalid = rsp_valid & (rsp_owner == X). m0_douta = m1_douta = s_douta (broadcast; qualified by rvalid).
- Writes produce an rvalid ack one cycle later like reads; douta content then undefined.
- Master rule: a master whose req is not granted holds req, addra, dina, wea stable until gnt. A master may deassert req only after gnt. Arbiter does not check this.
- No buffering: exactly one access in flight per cycle; throughput one access per cycle total.

## Timing
- Reset values (rst high at an edge): last_gnt = 1 (master 0 wins first conflict), rsp_valid = 0, rsp_owner = 0. While rst is high: m0_gnt = m1_gnt = 0, s_ena = 0, s_wea = 0, both rvalid = 0.
- Grant latency: 0 cycles (gnt same cycle as req when granted). Response latency: rvalid exactly 1 cycle after gnt.
- Back-to-back: a master may be granted on consecutive cycles if the other is idle; responses stream one per cycle in grant order.
- Persistent conflict: grants alternate m0, m1, m0, ...; a waiting master is granted within 1 cycle of a conflict (starvation bound 1).
- Reset mid-operation: a response pending from the cycle before rst is dropped (rvalid stays 0); the masters must reissue.
- Grant in the same cycle as another master's rvalid is legal; the two are independent.

## Test plan
- Reset: drive rst 2 cycles with both req=1 -> no gnt, s_ena=0, rvalid=0; first cycle after rst with both req -> m0_gnt=1 only.
- Single read: preload slave addr 0x100 = 0xDEADBEEF_CAFEF00D; m1 reads 0x100 alone -> m1_gnt same cycle, next cycle m1_rvalid=1, m1_douta=0xDEADBEEF_CAFEF00D, m0_rvalid=0.
- Conflict: both request continuously for 6 cycles -> grants m0,m1,m0,m1,m0,m1; each rvalid lands on the matching master one cycle later.
- Write then read: m0 writes 0x11223344_55667788 to 0x40 with wea=0x0F, m1 reads 0x40 next -> m1 reads low 4 bytes updated, upper bytes unchanged; m0_rvalid ack one cycle after its gnt.
- Hold rule: m1 loses a conflict -> m1 keeps req/addra stable, gnt next cycle, correct data returned; no s_ena for the unchosen request in the losing cycle.
- Reset with read in flight: assert rst the cycle after a grant -> rvalid stays 0 through reset, last_gnt reset to 1.

Source files
------------

// File: rtl/sram_arbiter2.sv
// sram_arbiter2 -- shares one synchronous SRAM port (1-cycle read latency)
// between two masters. Round-robin on conflict, grant in the request cycle,
// registered response tag so each response returns only to its issuer.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mX_req/addra/dina/wea     master X request (wea == 0 means read)
//   mX_gnt                    request of master X accepted this cycle
//   mX_douta/mX_rvalid        response to master X, one cycle after gnt
//   s_addra/dina/wea/ena      slave port command
//   s_douta                   slave read data, valid the cycle after s_ena

// Per-master response lane: qualifies the broadcast read data with the tag.
module sram_arbiter2_rsp #(
  parameter int LEN_DATA = 64,
  parameter int IDX      = 0
) (
  input  logic                rst,
  input  logic                rsp_valid,
  input  logic                rsp_owner,
  input  logic [LEN_DATA-1:0] s_douta,
  output logic                rvalid,
  output logic [LEN_DATA-1:0] douta
);
  // Gated by rst so a response issued the cycle before reset is dropped.
  assign rvalid = rsp_valid & ~rst & (rsp_owner == 1'(IDX));
  assign douta  = s_douta;
endmodule

module sram_arbiter2 #(
  parameter int LEN_ADDR = 64,
  parameter int LEN_DATA = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic [LEN_ADDR-1:0]   m0_addra,
  input  logic [LEN_DATA-1:0]   m0_dina,
  input  logic [LEN_DATA/8-1:0] m0_wea,
  output logic                  m0_gnt,
  output logic [LEN_DATA-1:0]   m0_douta,
  output logic                  m0_rvalid,
  input  logic                  m1_req,
  input  logic [LEN_ADDR-1:0]   m1_addra,
  input  logic [LEN_DATA-1:0]   m1_dina,
  input  logic [LEN_DATA/8-1:0] m1_wea,
  output logic                  m1_gnt,
  output logic [LEN_DATA-1:0]   m1_douta,
  output logic                  m1_rvalid,
  output logic [LEN_ADDR-1:0]   s_addra,
  output logic [LEN_DATA-1:0]   s_dina,
  output logic [LEN_DATA/8-1:0] s_wea,
  output logic                  s_ena,
  input  logic [LEN_DATA-1:0]   s_douta
);
  localparam int NUM_M = 2;

  logic             last_gnt;   // master granted most recently
  logic             rsp_valid;  // an access was issued last cycle
  logic             rsp_owner;  // which master issued it
  logic [NUM_M-1:0] req, gnt;
  logic [NUM_M-1:0] rvalid;
  logic [NUM_M-1:0][LEN_DATA-1:0] douta;

  assign req = {m1_req, m0_req};

  // On conflict the master that did not win last time gets the port,
  // bounding starvation to one cycle.
  always_comb begin
    gnt = '0;
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  // Idle cycles forward master 0's address/data so the bus is deterministic;
  // s_wea is forced to zero so nothing is written.
  assign s_ena   = |gnt;
  assign s_addra = gnt[1] ? m1_addra : m0_addra;
  assign s_dina  = gnt[1] ? m1_dina  : m0_dina;
  assign s_wea   = gnt[1] ? m1_wea : (gnt[0] ? m0_wea : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt  <= 1'b1;   // master 0 wins the first conflict
      rsp_valid <= 1'b0;
      rsp_owner <= 1'b0;
    end else if (|gnt) begin
      last_gnt  <= gnt[1];
      rsp_valid <= 1'b1;
      rsp_owner <= gnt[1];
    end else begin
      rsp_valid <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_M; i++) begin : g_rsp
    sram_arbiter2_rsp #(.LEN_DATA(LEN_DATA), .IDX(i)) u_rsp (
      .rst       (rst),
      .rsp_valid (rsp_valid),
      .rsp_owner (rsp_owner),
      .s_douta   (s_douta),
      .rvalid    (rvalid[i]),
      .douta     (douta[i])
    );
  end

  assign m0_rvalid = rvalid[0];
  assign m1_rvalid = rvalid[1];
  assign m0_douta  = douta[0];
  assign m1_douta  = douta[1];
endmodule

// File: tb/tb_sram_arbiter2.sv
module tb_sram_arbiter2;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_ena;
  logic [63:0] m0_addra, m1_addra, m0_dina, m1_dina, m0_douta, m1_douta;
  logic [63:0] s_addra, s_dina, s_douta;
  logic [7:0]  m0_wea, m1_wea, s_wea;

  int ntest = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  sram_arbiter2 #(.LEN_ADDR(64), .LEN_DATA(64)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addra(m0_addra), .m0_dina(m0_dina), .m0_wea(m0_wea),
    .m0_gnt(m0_gnt), .m0_douta(m0_douta), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_addra(m1_addra), .m1_dina(m1_dina), .m1_wea(m1_wea),
    .m1_gnt(m1_gnt), .m1_douta(m1_douta), .m1_rvalid(m1_rvalid),
    .s_addra(s_addra), .s_dina(s_dina), .s_wea(s_wea), .s_ena(s_ena),
    .s_douta(s_douta)
  );

  // Synchronous SRAM model, one-cycle read latency, byte write enables.
  logic [63:0] mem [0:511];
  always @(posedge clk) begin
    if (s_ena) begin
      for (int b = 0; b < 8; b++)
        if (s_wea[b]) mem[s_addra[8:0]][b*8 +: 8] <= s_dina[b*8 +: 8];
      s_douta <= mem[s_addra[8:0]];
    end
  end

  localparam logic [63:0] M10  = 64'h1010_1010_0000_0010;
  localparam logic [63:0] M20  = 64'h2020_2020_0000_0020;
  localparam logic [63:0] M100 = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] M40  = 64'hAAAAAAAA_BBBBBBBB;
  localparam logic [63:0] WD   = 64'h11223344_55667788;
  localparam logic [63:0] DA   = 64'hA5A5A5A5_12345678;
  localparam logic [63:0] DB   = 64'h0BADF00D_87654321;

  typedef struct packed {
    logic        rst;
    logic        r0; logic [15:0] a0; logic [7:0] w0; logic [63:0] d0;
    logic        r1; logic [15:0] a1; logic [7:0] w1; logic [63:0] d1;
    logic [1:0]  egnt;   // {m1_gnt, m0_gnt}
    logic        eena;
    logic [7:0]  ewea;
    logic [15:0] eaddr;
    logic [1:0]  erv;    // {m1_rvalid, m0_rvalid}
    logic        cdat;   // check douta of the responding master
    logic [63:0] edat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic q0, input logic [63:0] a0,
                       input logic [7:0] w0, input logic [63:0] d0,
                       input logic q1, input logic [63:0] a1,
                       input logic [7:0] w1, input logic [63:0] d1);
    rst = r;
    m0_req = q0; m0_addra = a0; m0_wea = w0; m0_dina = d0;
    m1_req = q1; m1_addra = a1; m1_wea = w1; m1_dina = d1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 64'h0;
    mem[9'h010] = M10;
    mem[9'h020] = M20;
    mem[9'h100] = M100;
    mem[9'h040] = M40;
    drive(1'b1, 1'b0, 64'h0, 8'h0, 64'h0, 1'b0, 64'h0, 8'h0, 64'h0);

    //            rst r0 a0      w0     d0  r1 a1       w1     d1    gnt   ena ewea   eaddr    erv   cd edat
    vecs.push_back('{1, 1,16'h30, 8'hFF, 0,  1,16'h20,  8'h00, 0,    2'b00, 0, 8'h00, 16'h30,  2'b00, 0, 0});    // 0 reset
    vecs.push_back('{1, 1,16'h30, 8'hFF, 0,  1,16'h20,  8'h00, 0,    2'b00, 0, 8'h00, 16'h30,  2'b00, 0, 0});    // 1 reset
    vecs.push_back('{0, 1,16'h10, 8'h00, 0,  1,16'h20,  8'h00, 0,    2'b01, 1, 8'h00, 16'h10,  2'b00, 0, 0});    // 2 conflict: m0 first
    vecs.push_back('{0, 1,16'h10, 8'h00, 0,  1,16'h20,  8'h00, 0,    2'b10, 1, 8'h00, 16'h20,  2'b01, 1, M10});  // 3
    vecs.push_back('{0, 1,16'h10, 8'h00, 0,  1,16'h20,  8'h00, 0,    2'b01, 1, 8'h00, 16'h10,  2'b10, 1, M20});  // 4
    vecs.push_back('{0, 1,16'h10, 8'h00, 0,  1,16'h20,  8'h00, 0,    2'b10, 1, 8'h00, 16'h20,  2'b01, 1, M10});  // 5
    vecs.push_back('{0, 1,16'h10, 8'h00, 0,  1,16'h20,  8'h00, 0,    2'b01, 1, 8'h00, 16'h10,  2'b10, 1, M20});  // 6
    vecs.push_back('{0, 1,16'h10, 8'h00, 0,  1,16'h20,  8'h00, 0,    2'b10, 1, 8'h00, 16'h20,  2'b01, 1, M10});  // 7
    vecs.push_back('{0, 0,16'h0,  8'h00, 0,  0,16'h0,   8'h00, 0,    2'b00, 0, 8'h00, 16'h0,   2'b10, 1, M20});  // 8 idle
    vecs.push_back('{0, 0,16'h0,  8'h00, 0,  1,16'h100, 8'h00, 0,    2'b10, 1, 8'h00, 16'h100, 2'b00, 0, 0});    // 9 m1 single read
    vecs.push_back('{0, 0,16'h0,  8'h00, 0,  0,16'h0,   8'h00, 0,    2'b00, 0, 8'h00, 16'h0,   2'b10, 1, M100}); // 10
    vecs.push_back('{0, 1,16'h40, 8'h0F, WD, 0,16'h0,   8'h00, 0,    2'b01, 1, 8'h0F, 16'h40,  2'b00, 0, 0});    // 11 m0 write
    vecs.push_back('{0, 0,16'h0,  8'h00, 0,  1,16'h40,  8'h00, 0,    2'b10, 1, 8'h00, 16'h40,  2'b01, 0, 0});    // 12 m1 read, m0 ack
    vecs.push_back('{0, 0,16'h0,  8'h00, 0,  0,16'h0,   8'h00, 0,    2'b00, 0, 8'h00, 16'h0,   2'b10, 1, 64'hAAAAAAAA_55667788}); // 13
    vecs.push_back('{0, 1,16'h10, 8'h00, 0,  1,16'h100, 8'h00, 0,    2'b01, 1, 8'h00, 16'h10,  2'b00, 0, 0});    // 14 m1 loses
    vecs.push_back('{0, 0,16'h0,  8'h00, 0,  1,16'h100, 8'h00, 0,    2'b10, 1, 8'h00, 16'h100, 2'b01, 1, M10});  // 15 m1 holds
    vecs.push_back('{0, 0,16'h0,  8'h00, 0,  0,16'h0,   8'h00, 0,    2'b00, 0, 8'h00, 16'h0,   2'b10, 1, M100}); // 16
    vecs.push_back('{0, 1,16'h100,8'h00, 0,  0,16'h0,   8'h00, 0,    2'b01, 1, 8'h00, 16'h100, 2'b00, 0, 0});    // 17 back-to-back m0
    vecs.push_back('{0, 1,16'h20, 8'h00, 0,  0,16'h0,   8'h00, 0,    2'b01, 1, 8'h00, 16'h20,  2'b01, 1, M100}); // 18
    vecs.push_back('{0, 0,16'h0,  8'h00, 0,  0,16'h0,   8'h00, 0,    2'b00, 0, 8'h00, 16'h0,   2'b01, 1, M20});  // 19
    vecs.push_back('{0, 0,16'h0,  8'h00, 0,  1,16'h10,  8'h00, 0,    2'b10, 1, 8'h00, 16'h10,  2'b00, 0, 0});    // 20 m1 read
    vecs.push_back('{1, 1,16'h10, 8'h00, 0,  1,16'h20,  8'h00, 0,    2'b00, 0, 8'h00, 16'h10,  2'b00, 0, 0});    // 21 reset drops it
    vecs.push_back('{0, 1,16'h10, 8'h00, 0,  1,16'h20,  8'h00, 0,    2'b01, 1, 8'h00, 16'h10,  2'b00, 0, 0});    // 22 m0 wins again
    vecs.push_back('{0, 0,16'h0,  8'h00, 0,  0,16'h0,   8'h00, 0,    2'b00, 0, 8'h00, 16'h0,   2'b01, 1, M10});  // 23

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      @(posedge clk); #1;
      drive(v.rst, v.r0, 64'(v.a0), v.w0, v.d0, v.r1, 64'(v.a1), v.w1, v.d1);
      #3;
      chk($sformatf("v%0d_gnt", i),   64'({m1_gnt, m0_gnt}), 64'(v.egnt));
      chk($sformatf("v%0d_ena", i),   64'(s_ena), 64'(v.eena));
      chk($sformatf("v%0d_wea", i),   64'(s_wea), 64'(v.ewea));
      chk($sformatf("v%0d_addr", i),  s_addra, 64'(v.eaddr));
      chk($sformatf("v%0d_rv", i),    64'({m1_rvalid, m0_rvalid}), 64'(v.erv));
      if (v.cdat)
        chk($sformatf("v%0d_data", i), v.erv[1] ? m1_douta : m0_douta, v.edat);
    end

    // Conflicting writes: m0 won last, so m1 goes first; check the data mux.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 64'h50, 8'hF0, DA, 1'b1, 64'h60, 8'hFF, DB);
    #3;
    chk("wr_m1_gnt",  64'({m1_gnt, m0_gnt}), 64'(2'b10));
    chk("wr_m1_dina", s_dina, DB);
    chk("wr_m1_wea",  64'(s_wea), 64'h FF);
    chk("wr_m1_addr", s_addra, 64'h60);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 64'h50, 8'hF0, DA, 1'b0, 64'h0, 8'h00, 64'h0);
    #3;
    chk("wr_m0_gnt",  64'({m1_gnt, m0_gnt}), 64'(2'b01));
    chk("wr_m0_dina", s_dina, DA);
    chk("wr_m0_wea",  64'(s_wea), 64'hF0);
    chk("wr_m1_ack",  64'({m1_rvalid, m0_rvalid}), 64'(2'b10));
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 64'h60, 8'h00, 64'h0, 1'b0, 64'h0, 8'h00, 64'h0);
    #3;
    chk("rd60_gnt",   64'({m1_gnt, m0_gnt}), 64'(2'b01));
    chk("wr_m0_ack",  64'({m1_rvalid, m0_rvalid}), 64'(2'b01));
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1, 64'h50, 8'h00, 64'h0);
    #3;
    chk("rd60_rv",    64'({m1_rvalid, m0_rvalid}), 64'(2'b01));
    chk("rd60_data",  m0_douta, DB);
    chk("rd50_gnt",   64'({m1_gnt, m0_gnt}), 64'(2'b10));
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0, 64'h0, 8'h00, 64'h0);
    #3;
    chk("rd50_rv",    64'({m1_rvalid, m0_rvalid}), 64'(2'b10));
    chk("rd50_data",  m1_douta, {DA[63:32], 32'h0});

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
